// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter: round-robin arbiter that lets NUM_INPUTS cbus requesters share one downstream cbus.
// Latency: a request seen valid in an IDLE cycle is granted on that edge and appears on oreq the next cycle.
// Backpressure: the granted requester owns oreq and oresp until its last beat is accepted or it aborts.
//               Every other requester sees an all-zero response and waits.
//
// Ports:
//   clk       - single clock, rising edge
//   reset     - asynchronous, active-high
//   ireqs     - upstream requests, index 0 lowest
//   iresps    - upstream responses; only the selected entry is non-zero, and only while BUSY
//   oreq      - downstream request: the selected ireqs entry while BUSY, zero while IDLE
//   oresp     - downstream response from memory
//   grant_idx - the requester currently granted, or the last one granted (debug)

package cbus_pkg;

   typedef struct packed {
      logic        valid;
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [7:0]  len;     // beats - 1
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] rdata;
   } cbus_resp_t;

endpackage

module cbus_rr_arbiter
   import cbus_pkg::*;
#(
   parameter int NUM_INPUTS = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  cbus_req_t                     ireqs  [NUM_INPUTS],
   output cbus_resp_t                    iresps [NUM_INPUTS],
   output cbus_req_t                     oreq,
   input  cbus_resp_t                    oresp,
   output logic [$clog2(NUM_INPUTS)-1:0] grant_idx
);

   localparam int IDX_W = $clog2(NUM_INPUTS);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] sel_q, sel_d;
   logic [IDX_W-1:0] last_grant_q, last_grant_d;

   logic             win_vld;
   logic [IDX_W-1:0] win_idx;
   logic             busy_end;

   // Round-robin pick: walk from last_grant+1 upward with wrap. The offset
   // NUM_INPUTS lands back on last_grant itself, so a lone requester can win
   // again.
   always_comb begin
      int cand;
      win_vld = 1'b0;
      win_idx = '0;
      cand    = 0;
      for (int off = 1; off <= NUM_INPUTS; off++) begin
         cand = (int'(last_grant_q) + off) % NUM_INPUTS;
         if (!win_vld && ireqs[cand].valid) begin
            win_vld = 1'b1;
            win_idx = IDX_W'(cand);
         end
      end
   end

   // A transfer ends on the last accepted beat. It also ends when the owner
   // drops valid (abort), in which case that cycle's oresp is not looked at.
   always_comb begin
      busy_end = 1'b0;
      if (!ireqs[sel_q].valid) begin
         busy_end = 1'b1;
      end else if (oresp.ready && oresp.last) begin
         busy_end = 1'b1;
      end
   end

   // sel and last_grant only move on a grant out of IDLE. sel is therefore
   // frozen for the whole BUSY period. Every completion returns to IDLE, so
   // there is never a BUSY-to-BUSY handoff.
   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               state_d      = BUSY;
               sel_d        = win_idx;
               last_grant_d = win_idx;
            end
         end
         BUSY: begin
            if (busy_end) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // last_grant resets to the top index so that requester 0 wins the first
   // contention.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         sel_q        <= '0;
         last_grant_q <= IDX_W'(NUM_INPUTS - 1);
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         last_grant_q <= last_grant_d;
      end
   end

   // The data path depends only on state_q and the live inputs. Because of
   // that, an asynchronous reset zeroes oreq and iresps at once, without
   // waiting for a clock edge.
   always_comb begin
      oreq = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         iresps[i] = '0;
         if (state_q == BUSY && sel_q == IDX_W'(i)) begin
            iresps[i] = oresp;
         end
      end
      if (state_q == BUSY) begin
         oreq = ireqs[sel_q];
      end
   end

   // last_grant is loaded together with sel on every grant. It therefore
   // equals sel throughout BUSY and holds the last grant in IDLE, so it can
   // drive the debug output straight from a register.
   assign grant_idx = last_grant_q;

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
module tb_cbus_rr_arbiter;
   import cbus_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   cbus_req_t  ireqs2 [2];
   cbus_resp_t iresps2[2];
   cbus_req_t  oreq2;
   cbus_resp_t oresp2;
   logic [0:0] gidx2;

   cbus_req_t  ireqs4 [4];
   cbus_resp_t iresps4[4];
   cbus_req_t  oreq4;
   cbus_resp_t oresp4;
   logic [1:0] gidx4;

   int n_checks = 0;
   int n_fail   = 0;

   cbus_rr_arbiter #(.NUM_INPUTS(2)) dut2 (
      .clk(clk), .reset(reset), .ireqs(ireqs2), .iresps(iresps2),
      .oreq(oreq2), .oresp(oresp2), .grant_idx(gidx2)
   );

   cbus_rr_arbiter #(.NUM_INPUTS(4)) dut4 (
      .clk(clk), .reset(reset), .ireqs(ireqs4), .iresps(iresps4),
      .oreq(oreq4), .oresp(oresp4), .grant_idx(gidx4)
   );

   function automatic cbus_req_t mk_req(input logic [31:0] addr, input logic [7:0] len);
      cbus_req_t r;
      r       = '0;
      r.valid = 1'b1;
      r.addr  = addr;
      r.len   = len;
      return r;
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      for (int i = 0; i < 2; i++) ireqs2[i] = '0;
      for (int i = 0; i < 4; i++) ireqs4[i] = '0;
      oresp2 = '0;
      oresp4 = '0;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      clear_inputs();
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      clear_inputs();
      step();
      ireqs2[0] = mk_req(32'h1000, 8'd0);
      ireqs4[2] = mk_req(32'h2000, 8'd0);
      step();
      n_checks++; if (oreq2 !== '0) begin n_fail++; $display("FAIL reset_oreq2: got %h expected 0", oreq2); end
      n_checks++; if (oreq4 !== '0) begin n_fail++; $display("FAIL reset_oreq4: got %h expected 0", oreq4); end
      n_checks++; if (iresps2[0] !== '0 || iresps2[1] !== '0) begin n_fail++; $display("FAIL reset_iresps2: got %h %h expected 0", iresps2[0], iresps2[1]); end
      n_checks++; if (gidx2 !== 1'b1) begin n_fail++; $display("FAIL reset_gidx2: got %0d expected 1", gidx2); end
      n_checks++; if (gidx4 !== 2'd3) begin n_fail++; $display("FAIL reset_gidx4: got %0d expected 3", gidx4); end
      clear_inputs();
      reset = 1'b0;
   endtask

   task automatic test_single;
      cbus_req_t r;
      do_reset();
      r = mk_req(32'h8000_0000, 8'd0);
      ireqs2[1] = r;                                      // cycle 0
      #1;
      n_checks++; if (oreq2.valid !== 1'b0) begin n_fail++; $display("FAIL single_c0_idle: oreq.valid got %b expected 0", oreq2.valid); end
      step();                                             // cycle 1
      n_checks++; if (oreq2 !== r) begin n_fail++; $display("FAIL single_c1_oreq: got %h expected %h", oreq2, r); end
      n_checks++; if (gidx2 !== 1'b1) begin n_fail++; $display("FAIL single_c1_gidx: got %0d expected 1", gidx2); end
      step();                                             // cycle 2
      step();                                             // cycle 3
      step();                                             // cycle 4
      oresp2.ready = 1'b1;
      oresp2.last  = 1'b1;
      oresp2.rdata = 32'hDEAD_BEEF;
      #1;
      n_checks++; if (iresps2[1].last !== 1'b1 || iresps2[1].rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_c4_resp: got %h expected last=1 rdata=deadbeef", iresps2[1]); end
      n_checks++; if (iresps2[0] !== '0) begin n_fail++; $display("FAIL single_c4_other: got %h expected 0", iresps2[0]); end
      step();                                             // cycle 5
      oresp2 = '0;
      #1;
      n_checks++; if (oreq2.valid !== 1'b0) begin n_fail++; $display("FAIL single_c5_idle: oreq.valid got %b expected 0", oreq2.valid); end
      n_checks++; if (gidx2 !== 1'b1) begin n_fail++; $display("FAIL single_c5_gidx: got %0d expected 1", gidx2); end
      ireqs2[1] = '0;
   endtask

   task automatic test_contention;
      do_reset();
      ireqs2[0] = mk_req(32'hA000_0000, 8'd0);
      ireqs2[1] = mk_req(32'hB000_0000, 8'd0);
      step();
      n_checks++; if (gidx2 !== 1'b0) begin n_fail++; $display("FAIL cont_first_gidx: got %0d expected 0", gidx2); end
      n_checks++; if (oreq2.addr !== 32'hA000_0000) begin n_fail++; $display("FAIL cont_first_addr: got %h expected a0000000", oreq2.addr); end
      oresp2.ready = 1'b1;
      oresp2.last  = 1'b1;
      #1;
      n_checks++; if (iresps2[0].ready !== 1'b1) begin n_fail++; $display("FAIL cont_r0_ready: got %b expected 1", iresps2[0].ready); end
      n_checks++; if (iresps2[1] !== '0) begin n_fail++; $display("FAIL cont_r1_zero: got %h expected 0", iresps2[1]); end
      step();
      oresp2    = '0;
      ireqs2[0] = '0;
      #1;
      n_checks++; if (oreq2 !== '0) begin n_fail++; $display("FAIL cont_gap_idle: got %h expected 0", oreq2); end
      step();
      n_checks++; if (gidx2 !== 1'b1) begin n_fail++; $display("FAIL cont_second_gidx: got %0d expected 1", gidx2); end
      n_checks++; if (oreq2.addr !== 32'hB000_0000) begin n_fail++; $display("FAIL cont_second_addr: got %h expected b0000000", oreq2.addr); end
      oresp2.ready = 1'b1;
      oresp2.last  = 1'b1;
      step();
      clear_inputs();
   endtask

   task automatic test_burst;
      int beats0;
      beats0 = 0;
      // last_grant is 1 here, so the search starts at 0
      ireqs2[0] = mk_req(32'hC000_0000, 8'd7);
      ireqs2[1] = mk_req(32'hD000_0000, 8'd0);
      step();
      for (int b = 0; b < 8; b++) begin
         oresp2.ready = 1'b1;
         oresp2.last  = (b == 7);
         oresp2.rdata = 32'(b);
         #1;
         n_checks++; if (iresps2[1] !== '0) begin n_fail++; $display("FAIL burst_r1_beat%0d: got %h expected 0", b, iresps2[1]); end
         n_checks++; if (gidx2 !== 1'b0) begin n_fail++; $display("FAIL burst_gidx_beat%0d: got %0d expected 0", b, gidx2); end
         if (iresps2[0].ready === 1'b1 && iresps2[0].rdata === 32'(b)) beats0++;
         step();
      end
      n_checks++; if (beats0 != 8) begin n_fail++; $display("FAIL burst_beats: got %0d expected 8", beats0); end
      oresp2    = '0;
      ireqs2[0] = '0;
      #1;
      n_checks++; if (oreq2.valid !== 1'b0) begin n_fail++; $display("FAIL burst_gap_idle: oreq.valid got %b expected 0", oreq2.valid); end
      step();
      n_checks++; if (gidx2 !== 1'b1 || oreq2.addr !== 32'hD000_0000) begin n_fail++; $display("FAIL burst_next: got gidx=%0d addr=%h expected 1 d0000000", gidx2, oreq2.addr); end
      oresp2.ready = 1'b1;
      oresp2.last  = 1'b1;
      step();
      clear_inputs();
   endtask

   task automatic test_fairness;
      logic [1:0] exp;
      do_reset();
      for (int i = 0; i < 4; i++) ireqs4[i] = mk_req(32'h100 + 32'(i), 8'd0);
      for (int g = 0; g < 8; g++) begin
         exp = 2'(g % 4);
         step();
         n_checks++; if (gidx4 !== exp || oreq4.addr !== 32'h100 + 32'(exp)) begin n_fail++; $display("FAIL fair_grant%0d: got idx=%0d addr=%h expected %0d", g, gidx4, oreq4.addr, exp); end
         oresp4.ready = 1'b1;
         oresp4.last  = 1'b1;
         #1;
         n_checks++; if (iresps4[exp].last !== 1'b1) begin n_fail++; $display("FAIL fair_resp%0d: got %h expected last=1", g, iresps4[exp]); end
         step();
         oresp4 = '0;
         #1;
         n_checks++; if (oreq4.valid !== 1'b0) begin n_fail++; $display("FAIL fair_gap%0d: oreq.valid got %b expected 0", g, oreq4.valid); end
      end
      clear_inputs();
   endtask

   task automatic test_abort;
      do_reset();
      ireqs2[0] = mk_req(32'hE000_0000, 8'd3);
      step();                                             // first BUSY cycle
      n_checks++; if (gidx2 !== 1'b0 || oreq2.valid !== 1'b1) begin n_fail++; $display("FAIL abort_grant: got gidx=%0d valid=%b expected 0 1", gidx2, oreq2.valid); end
      step();                                             // second BUSY cycle
      ireqs2[0].valid = 1'b0;
      #1;
      n_checks++; if (oreq2.valid !== 1'b0) begin n_fail++; $display("FAIL abort_mirror: oreq.valid got %b expected 0", oreq2.valid); end
      step();
      ireqs2[0] = mk_req(32'hE000_0000, 8'd0);
      ireqs2[1] = mk_req(32'hF000_0000, 8'd0);
      #1;
      n_checks++; if (oreq2 !== '0) begin n_fail++; $display("FAIL abort_idle: got %h expected 0", oreq2); end
      n_checks++; if (gidx2 !== 1'b0) begin n_fail++; $display("FAIL abort_idle_gidx: got %0d expected 0", gidx2); end
      step();
      n_checks++; if (gidx2 !== 1'b1 || oreq2.addr !== 32'hF000_0000) begin n_fail++; $display("FAIL abort_next: got gidx=%0d addr=%h expected 1 f0000000", gidx2, oreq2.addr); end
      oresp2.ready = 1'b1;
      oresp2.last  = 1'b1;
      step();
      clear_inputs();
   endtask

   task automatic test_async_reset;
      // last_grant is 1 here, so requester 0 is granted
      ireqs2[0] = mk_req(32'h1234_0000, 8'd7);
      step();
      oresp2.ready = 1'b1;
      oresp2.last  = 1'b0;
      step();
      step();
      #2;
      reset = 1'b1;                                       // between edges
      #1;
      n_checks++; if (oreq2.valid !== 1'b0) begin n_fail++; $display("FAIL areset_oreq: valid got %b expected 0", oreq2.valid); end
      n_checks++; if (iresps2[0] !== '0 || iresps2[1] !== '0) begin n_fail++; $display("FAIL areset_iresps: got %h %h expected 0", iresps2[0], iresps2[1]); end
      n_checks++; if (gidx2 !== 1'b1) begin n_fail++; $display("FAIL areset_gidx: got %0d expected 1", gidx2); end
      step();
      clear_inputs();
      reset = 1'b0;
      ireqs2[0] = mk_req(32'h5555_0000, 8'd0);
      ireqs2[1] = mk_req(32'h6666_0000, 8'd0);
      step();
      n_checks++; if (gidx2 !== 1'b0 || oreq2.addr !== 32'h5555_0000) begin n_fail++; $display("FAIL areset_first_grant: got gidx=%0d addr=%h expected 0 55550000", gidx2, oreq2.addr); end
      oresp2.ready = 1'b1;
      oresp2.last  = 1'b1;
      step();
      clear_inputs();
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: time limit reached, got no end expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_inputs();
      test_reset();
      test_single();
      test_contention();
      test_burst();
      test_fairness();
      test_abort();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
